// File: rtl/badge_frame_rx.sv
// Badge-reader frame receiver: start/32 data/even-parity/stop framing with an
// inter-bit timeout and a post-accept hold-off so one swipe gives one id_valid.
module badge_frame_rx #(
  parameter int TIMEOUT = 1000,
  parameter int HOLDOFF = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_strobe,
  output logic [31:0] ID,
  output logic        id_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int GW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, HOLD} state_t;

  state_t          state, state_nx;
  logic [31:0]     shreg;
  logic [5:0]      bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            timeout, shift, accept, reject, in_frame;

  assign in_frame = (state == DATA) || (state == PARITY) || (state == STOP);
  // A strobe on the timeout edge is processed normally, so timeout needs quiet.
  assign timeout  = !bit_strobe && (gap_cnt == GW'(TIMEOUT - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    shift    = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    case (state)
      IDLE: if (bit_strobe && !bit_in) state_nx = DATA;
      DATA: begin
        if (bit_strobe) begin
          shift = 1'b1;
          if (bit_cnt == 6'd31) state_nx = PARITY;
        end else if (timeout) begin
          reject   = 1'b1;
          state_nx = IDLE;
        end
      end
      PARITY: begin
        if (bit_strobe) begin
          if (bit_in == ^shreg) state_nx = STOP;
          else begin
            reject   = 1'b1;
            state_nx = IDLE;
          end
        end else if (timeout) begin
          reject   = 1'b1;
          state_nx = IDLE;
        end
      end
      STOP: begin
        if (bit_strobe) begin
          if (bit_in) begin
            accept   = 1'b1;
            state_nx = HOLD;
          end else begin
            reject   = 1'b1;
            state_nx = IDLE;
          end
        end else if (timeout) begin
          reject   = 1'b1;
          state_nx = IDLE;
        end
      end
      // Strobes are ignored here, including one on the leaving edge.
      HOLD: if (hold_cnt == HW'(HOLDOFF - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      hold_cnt  <= '0;
      ID        <= '0;
      id_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      id_valid  <= accept;
      frame_err <= reject;
      if (shift) shreg <= {shreg[30:0], bit_in};
      if (accept) ID <= shreg;
      if (state == IDLE) bit_cnt <= '0;
      else if (shift)    bit_cnt <= bit_cnt + 6'd1;
      gap_cnt  <= (in_frame && !bit_strobe) ? gap_cnt + 1'b1 : '0;
      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_badge_frame_rx.sv
// Bench for badge_frame_rx: scenario tasks with inline checks plus an
// accepted-ID scoreboard fed by a negedge monitor.
module tb_badge_frame_rx;
  localparam int TIMEOUT = 1000;
  localparam int HOLDOFF = 200;

  logic        clk = 1'b0, rst = 1'b0, bit_in = 1'b0, bit_strobe = 1'b0;
  logic [31:0] ID;
  logic        id_valid, frame_err, busy;

  int checks = 0, passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int err_cnt = 0, both_cnt = 0;

  badge_frame_rx #(.TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_strobe(bit_strobe),
    .ID(ID), .id_valid(id_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (id_valid) obs_q.push_back(ID);
    if (frame_err) err_cnt++;
    if (id_valid && frame_err) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the sampling edge + gap-1 cycles.
  task automatic send_bit(input logic b, input int gap);
    bit_in = b; bit_strobe = 1'b1;
    @(posedge clk); #1;
    bit_strobe = 1'b0;
    for (int i = 1; i < gap; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send_body(input logic [31:0] d, input int nbits, input int gap);
    send_bit(1'b0, gap);
    for (int i = 31; i > 31 - nbits; i--) send_bit(d[i], gap);
  endtask

  task automatic send_valid(input logic [31:0] d, input int gap);
    send_body(d, 32, gap);
    send_bit(^d, gap);
    send_bit(1'b1, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < HOLDOFF + 2; i++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    checks++; if ({ID, id_valid, frame_err, busy} !== 35'h0)
      $display("FAIL reset_low: got %h/%b/%b/%b want 0/0/0/0", ID, id_valid, frame_err, busy); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ID, id_valid, frame_err, busy} !== 35'h0)
      $display("FAIL reset_release: got %h/%b/%b/%b want 0/0/0/0", ID, id_valid, frame_err, busy); else passes++;
  endtask

  task automatic test_valid();
    logic [31:0] d = 32'hDEADBEEF;
    exp_q.push_back(d);
    send_bit(1'b0, 4);
    checks++; if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy); else passes++;
    for (int i = 31; i >= 0; i--) send_bit(d[i], 4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 1);
    checks++; if (id_valid !== 1'b1 || frame_err !== 1'b0)
      $display("FAIL valid_pulse: got id_valid=%b frame_err=%b want 1/0", id_valid, frame_err); else passes++;
    checks++; if (ID !== d) $display("FAIL valid_id: got %h want %h", ID, d); else passes++;
    @(posedge clk); #1;
    checks++; if (id_valid !== 1'b0) $display("FAIL valid_one_cycle: got %b want 0", id_valid); else passes++;
    for (int i = 0; i < HOLDOFF - 2; i++) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) $display("FAIL busy_hold_end: got %b want 1", busy); else passes++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL busy_after_hold: got %b want 0", busy); else passes++;
    checks++; if (err_cnt !== 0) $display("FAIL valid_no_err: got %0d want 0", err_cnt); else passes++;
  endtask

  task automatic test_parity_err();
    send_body(32'h00000001, 32, 3);
    send_bit(1'b0, 1);
    checks++; if (frame_err !== 1'b1 || id_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL parity_err: got err=%b vld=%b busy=%b want 1/0/0", frame_err, id_valid, busy); else passes++;
    checks++; if (ID !== 32'hDEADBEEF) $display("FAIL parity_id_kept: got %h want deadbeef", ID); else passes++;
    @(posedge clk); #1;
    checks++; if (frame_err !== 1'b0) $display("FAIL parity_err_one_cycle: got %b want 0", frame_err); else passes++;
  endtask

  task automatic test_stop_err();
    logic [31:0] d = 32'h12345678;
    send_body(d, 32, 2);
    send_bit(^d, 2);
    send_bit(1'b0, 1);
    checks++; if (frame_err !== 1'b1 || id_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stop_err: got err=%b vld=%b busy=%b want 1/0/0", frame_err, id_valid, busy); else passes++;
    checks++; if (ID !== 32'hDEADBEEF) $display("FAIL stop_id_kept: got %h want deadbeef", ID); else passes++;
  endtask

  task automatic test_timeout();
    send_body(32'hFFFFFFFF, 10, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) begin @(posedge clk); #1; end
    checks++; if (frame_err !== 1'b0 || busy !== 1'b1)
      $display("FAIL timeout_early: got err=%b busy=%b want 0/1", frame_err, busy); else passes++;
    @(posedge clk); #1;
    checks++; if (frame_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_fire: got err=%b busy=%b want 1/0", frame_err, busy); else passes++;
    // start bit right on the edge after the error
    exp_q.push_back(32'hCAFEF00D);
    send_valid(32'hCAFEF00D, 2);
    checks++; if (id_valid !== 1'b1 || ID !== 32'hCAFEF00D)
      $display("FAIL timeout_recover: got vld=%b ID=%h want 1/cafef00d", id_valid, ID); else passes++;
    wait_idle();
    // gap of exactly TIMEOUT cycles: strobe lands on the timeout edge and wins
    exp_q.push_back(32'h0F1E2D3C);
    send_bit(1'b0, TIMEOUT);
    for (int i = 31; i >= 0; i--) send_bit(logic'(32'h0F1E2D3C >> i), 1);
    send_bit(^32'h0F1E2D3C, 1);
    send_bit(1'b1, 1);
    checks++; if (id_valid !== 1'b1 || ID !== 32'h0F1E2D3C)
      $display("FAIL timeout_edge_strobe: got vld=%b ID=%h want 1/0f1e2d3c", id_valid, ID); else passes++;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'hA5A5A5A5);
    send_valid(32'hA5A5A5A5, 1);
    for (int i = 0; i < 50; i++) begin @(posedge clk); #1; end
    send_valid(32'h5A5A5A5A, 1);
    checks++; if (busy !== 1'b1 || ID !== 32'hA5A5A5A5)
      $display("FAIL hold_discard: got busy=%b ID=%h want 1/a5a5a5a5", busy, ID); else passes++;
    for (int i = 0; i < HOLDOFF - 1 - 85; i++) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) $display("FAIL hold_last_cycle: got %b want 1", busy); else passes++;
    // start bit on the edge that leaves HOLD must be dropped
    send_bit(1'b0, 1);
    checks++; if (busy !== 1'b0) $display("FAIL hold_exit_strobe: got busy=%b want 0", busy); else passes++;
    exp_q.push_back(32'h5A5A5A5A);
    send_valid(32'h5A5A5A5A, 1);
    checks++; if (id_valid !== 1'b1 || ID !== 32'h5A5A5A5A)
      $display("FAIL hold_after_accept: got vld=%b ID=%h want 1/5a5a5a5a", id_valid, ID); else passes++;
    wait_idle();
  endtask

  task automatic test_reset_midframe();
    int e0;
    e0 = err_cnt;
    send_body(32'hFFFF0000, 20, 2);
    #2 rst = 1'b0;
    #1;
    checks++; if ({ID, id_valid, frame_err, busy} !== 35'h0)
      $display("FAIL reset_async: got %h/%b/%b/%b want 0/0/0/0", ID, id_valid, frame_err, busy); else passes++;
    @(posedge clk); #4 rst = 1'b1;
    @(posedge clk); #1;
    send_bit(1'b1, 2);
    checks++; if (busy !== 1'b0 || err_cnt !== e0)
      $display("FAIL reset_no_err: got busy=%b errs=%0d want 0/%0d", busy, err_cnt, e0); else passes++;
    exp_q.push_back(32'h3C3C1234);
    send_valid(32'h3C3C1234, 3);
    checks++; if (id_valid !== 1'b1 || ID !== 32'h3C3C1234)
      $display("FAIL reset_recover: got vld=%b ID=%h want 1/3c3c1234", id_valid, ID); else passes++;
    wait_idle();
  endtask

  task automatic test_scoreboard();
    logic [31:0] e, o;
    checks++; if (obs_q.size() !== exp_q.size())
      $display("FAIL sb_count: got %0d accepts want %0d", obs_q.size(), exp_q.size()); else passes++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL sb_id: got %h want %h", o, e); else passes++;
    end
    checks++; if (err_cnt !== 3) $display("FAIL sb_err_count: got %0d want 3", err_cnt); else passes++;
    checks++; if (both_cnt !== 0) $display("FAIL sb_exclusive: got %0d overlaps want 0", both_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_valid();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    test_scoreboard();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
